// File: rtl/lsu_issue_queue_if.sv
// Dispatch, CDB wakeup, ROB head and LSU issue signals of the LSU issue queue.
// The queue connects through the slave modport; its driver uses the master modport.
interface lsu_issue_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int DEPTH      = 8
);
    logic                    i_flush;
    logic                    i_disp_valid;
    logic                    o_disp_ready;
    logic                    i_disp_memwrite;
    logic [DATA_WIDTH-1:0]   i_disp_offset;
    logic [PREG_WIDTH-1:0]   i_disp_rs1_tag;
    logic [PREG_WIDTH-1:0]   i_disp_rs2_tag;
    logic                    i_disp_rs1_rdy;
    logic                    i_disp_rs2_rdy;
    logic [DATA_WIDTH-1:0]   i_disp_rs1_val;
    logic [DATA_WIDTH-1:0]   i_disp_rs2_val;
    logic [PREG_WIDTH-1:0]   i_disp_prd;
    logic [ROB_WIDTH-1:0]    i_disp_rob_tag;
    logic                    i_cdb_valid;
    logic [PREG_WIDTH-1:0]   i_cdb_tag;
    logic [DATA_WIDTH-1:0]   i_cdb_data;
    logic [ROB_WIDTH-1:0]    i_rob_head_tag;
    logic                    o_lsu_valid;
    logic                    o_lsu_memwrite;
    logic [DATA_WIDTH-1:0]   o_lsu_base_addr;
    logic [DATA_WIDTH-1:0]   o_lsu_offset;
    logic [DATA_WIDTH-1:0]   o_lsu_store_data;
    logic [PREG_WIDTH-1:0]   o_lsu_prd;
    logic [ROB_WIDTH-1:0]    o_lsu_rob_tag;
    logic [$clog2(DEPTH):0]  o_count;

    modport slave (
        input  i_flush, i_disp_valid, i_disp_memwrite, i_disp_offset,
               i_disp_rs1_tag, i_disp_rs2_tag, i_disp_rs1_rdy, i_disp_rs2_rdy,
               i_disp_rs1_val, i_disp_rs2_val, i_disp_prd, i_disp_rob_tag,
               i_cdb_valid, i_cdb_tag, i_cdb_data, i_rob_head_tag,
        output o_disp_ready, o_lsu_valid, o_lsu_memwrite, o_lsu_base_addr,
               o_lsu_offset, o_lsu_store_data, o_lsu_prd, o_lsu_rob_tag, o_count
    );

    modport master (
        output i_flush, i_disp_valid, i_disp_memwrite, i_disp_offset,
               i_disp_rs1_tag, i_disp_rs2_tag, i_disp_rs1_rdy, i_disp_rs2_rdy,
               i_disp_rs1_val, i_disp_rs2_val, i_disp_prd, i_disp_rob_tag,
               i_cdb_valid, i_cdb_tag, i_cdb_data, i_rob_head_tag,
        input  o_disp_ready, o_lsu_valid, o_lsu_memwrite, o_lsu_base_addr,
               o_lsu_offset, o_lsu_store_data, o_lsu_prd, o_lsu_rob_tag, o_count
    );
endinterface

// File: rtl/lsu_issue_queue.sv
// In-order load/store issue queue: captures operands at dispatch or from the CDB
// and issues the head entry to the LSU once its operands (and, for stores, commit) allow.
module lsu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int DEPTH      = 8
) (
    input  logic               clk,
    input  logic               reset,
    lsu_issue_queue_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      memwrite_q, memwrite_d;
    logic [DEPTH-1:0]      rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0]      rs2_rdy_q, rs2_rdy_d;
    logic [DATA_WIDTH-1:0] offset_q  [DEPTH];
    logic [DATA_WIDTH-1:0] offset_d  [DEPTH];
    logic [DATA_WIDTH-1:0] rs1_val_q [DEPTH];
    logic [DATA_WIDTH-1:0] rs1_val_d [DEPTH];
    logic [DATA_WIDTH-1:0] rs2_val_q [DEPTH];
    logic [DATA_WIDTH-1:0] rs2_val_d [DEPTH];
    logic [PREG_WIDTH-1:0] rs1_tag_q [DEPTH];
    logic [PREG_WIDTH-1:0] rs1_tag_d [DEPTH];
    logic [PREG_WIDTH-1:0] rs2_tag_q [DEPTH];
    logic [PREG_WIDTH-1:0] rs2_tag_d [DEPTH];
    logic [PREG_WIDTH-1:0] prd_q     [DEPTH];
    logic [PREG_WIDTH-1:0] prd_d     [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_tag_q [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_tag_d [DEPTH];

    logic                  lsu_valid_q, lsu_valid_d;
    logic                  lsu_memwrite_q, lsu_memwrite_d;
    logic [DATA_WIDTH-1:0] lsu_base_q, lsu_base_d;
    logic [DATA_WIDTH-1:0] lsu_offset_q, lsu_offset_d;
    logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;
    logic [PREG_WIDTH-1:0] lsu_prd_q, lsu_prd_d;
    logic [ROB_WIDTH-1:0]  lsu_rob_q, lsu_rob_d;

    logic [IDX_W-1:0]      head_idx, tail_idx;
    logic                  full, disp_fire, issue;
    logic                  disp_rs1_hit, disp_rs2_hit;

    assign head_idx  = head_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign full      = (head_q ^ tail_q) == {1'b1, {IDX_W{1'b0}}};
    assign disp_fire = bus.i_disp_valid && !full;

    // A store additionally waits for store data and for being the oldest uncommitted op.
    assign issue = valid_q[head_idx] && rs1_rdy_q[head_idx] &&
                   (!memwrite_q[head_idx] ||
                    (rs2_rdy_q[head_idx] && (rob_tag_q[head_idx] == bus.i_rob_head_tag)));

    assign disp_rs1_hit = bus.i_cdb_valid && !bus.i_disp_rs1_rdy &&
                          (bus.i_cdb_tag == bus.i_disp_rs1_tag);
    assign disp_rs2_hit = bus.i_cdb_valid && bus.i_disp_memwrite && !bus.i_disp_rs2_rdy &&
                          (bus.i_cdb_tag == bus.i_disp_rs2_tag);

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        valid_d        = valid_q;
        memwrite_d     = memwrite_q;
        rs1_rdy_d      = rs1_rdy_q;
        rs2_rdy_d      = rs2_rdy_q;
        offset_d       = offset_q;
        rs1_val_d      = rs1_val_q;
        rs2_val_d      = rs2_val_q;
        rs1_tag_d      = rs1_tag_q;
        rs2_tag_d      = rs2_tag_q;
        prd_d          = prd_q;
        rob_tag_d      = rob_tag_q;
        lsu_valid_d    = issue;
        lsu_memwrite_d = lsu_memwrite_q;
        lsu_base_d     = lsu_base_q;
        lsu_offset_d   = lsu_offset_q;
        lsu_data_d     = lsu_data_q;
        lsu_prd_d      = lsu_prd_q;
        lsu_rob_d      = lsu_rob_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (bus.i_cdb_valid && valid_q[i]) begin
                if (!rs1_rdy_q[i] && (rs1_tag_q[i] == bus.i_cdb_tag)) begin
                    rs1_rdy_d[i] = 1'b1;
                    rs1_val_d[i] = bus.i_cdb_data;
                end
                if (!rs2_rdy_q[i] && (rs2_tag_q[i] == bus.i_cdb_tag)) begin
                    rs2_rdy_d[i] = 1'b1;
                    rs2_val_d[i] = bus.i_cdb_data;
                end
            end
        end

        if (issue) begin
            lsu_memwrite_d    = memwrite_q[head_idx];
            lsu_base_d        = rs1_val_q[head_idx];
            lsu_offset_d      = offset_q[head_idx];
            lsu_data_d        = rs2_val_q[head_idx];
            lsu_prd_d         = prd_q[head_idx];
            lsu_rob_d         = rob_tag_q[head_idx];
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_W'(1);
        end

        // The tail entry is never valid here, so it cannot collide with wakeup or issue.
        if (disp_fire) begin
            valid_d[tail_idx]    = 1'b1;
            memwrite_d[tail_idx] = bus.i_disp_memwrite;
            offset_d[tail_idx]   = bus.i_disp_offset;
            rs1_tag_d[tail_idx]  = bus.i_disp_rs1_tag;
            rs2_tag_d[tail_idx]  = bus.i_disp_rs2_tag;
            prd_d[tail_idx]      = bus.i_disp_prd;
            rob_tag_d[tail_idx]  = bus.i_disp_rob_tag;
            rs1_rdy_d[tail_idx]  = bus.i_disp_rs1_rdy || disp_rs1_hit;
            rs1_val_d[tail_idx]  = disp_rs1_hit ? bus.i_cdb_data : bus.i_disp_rs1_val;
            rs2_rdy_d[tail_idx]  = !bus.i_disp_memwrite || bus.i_disp_rs2_rdy || disp_rs2_hit;
            rs2_val_d[tail_idx]  = disp_rs2_hit ? bus.i_cdb_data : bus.i_disp_rs2_val;
            tail_d               = tail_q + PTR_W'(1);
        end

        if (bus.i_flush) begin
            valid_d     = '0;
            head_d      = '0;
            tail_d      = '0;
            lsu_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            valid_q        <= '0;
            memwrite_q     <= '0;
            rs1_rdy_q      <= '0;
            rs2_rdy_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                offset_q[i]  <= '0;
                rs1_val_q[i] <= '0;
                rs2_val_q[i] <= '0;
                rs1_tag_q[i] <= '0;
                rs2_tag_q[i] <= '0;
                prd_q[i]     <= '0;
                rob_tag_q[i] <= '0;
            end
            lsu_valid_q    <= 1'b0;
            lsu_memwrite_q <= 1'b0;
            lsu_base_q     <= '0;
            lsu_offset_q   <= '0;
            lsu_data_q     <= '0;
            lsu_prd_q      <= '0;
            lsu_rob_q      <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            valid_q        <= valid_d;
            memwrite_q     <= memwrite_d;
            rs1_rdy_q      <= rs1_rdy_d;
            rs2_rdy_q      <= rs2_rdy_d;
            offset_q       <= offset_d;
            rs1_val_q      <= rs1_val_d;
            rs2_val_q      <= rs2_val_d;
            rs1_tag_q      <= rs1_tag_d;
            rs2_tag_q      <= rs2_tag_d;
            prd_q          <= prd_d;
            rob_tag_q      <= rob_tag_d;
            lsu_valid_q    <= lsu_valid_d;
            lsu_memwrite_q <= lsu_memwrite_d;
            lsu_base_q     <= lsu_base_d;
            lsu_offset_q   <= lsu_offset_d;
            lsu_data_q     <= lsu_data_d;
            lsu_prd_q      <= lsu_prd_d;
            lsu_rob_q      <= lsu_rob_d;
        end
    end

    assign bus.o_disp_ready     = !full;
    assign bus.o_count          = tail_q - head_q;
    assign bus.o_lsu_valid      = lsu_valid_q;
    assign bus.o_lsu_memwrite   = lsu_memwrite_q;
    assign bus.o_lsu_base_addr  = lsu_base_q;
    assign bus.o_lsu_offset     = lsu_offset_q;
    assign bus.o_lsu_store_data = lsu_data_q;
    assign bus.o_lsu_prd        = lsu_prd_q;
    assign bus.o_lsu_rob_tag    = lsu_rob_q;
endmodule
